multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Moore-style control sequencer for the 16-bit multi-cycle processor.
- Decodes the registered OPCODE from the instruction register and drives all datapath control strobes (C_IRWrite, PC, memory, register-file, ALU muxes) per state.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter (saturating)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
OPCODE  input  4  opcode from instruction register
D_MemReady  input  1  memory completes current read/write this cycle
C_IRWrite  output  1  instruction register load enable
C_PCWrite  output  1  unconditional PC write
C_PCWriteCond  output  1  PC write if ALU zero
C_MemRead  output  1  memory read strobe
C_MemWrite  output  1  memory write strobe
C_IorD  output  1  0=PC address, 1=ALU-out address
C_RegWrite  output  1  register file write
C_MemToReg  output  1  0=ALU-out, 1=memory data to register file
C_ALUSrcA  output  1  0=PC, 1=reg A
C_ALUSrcB  output  2  00=reg B, 01=const 1, 10=sign-ext offset, 11=branch offset
C_ALUOp  output  2  00=add, 01=subtract, 10=use FUNCFIELD
C_PCSource  output  2  00=ALU result, 01=ALU-out, 10=jump target
state_o  output  4  current state encoding
halted  output  1  HALT reached
trap  output  1  illegal opcode trapped (feature only; else 0)
retired_count  output  CNT_W  retired instructions, saturating

Behaviour:
- Opcodes: 0x0 R-type ALU, 0x1 LW, 0x2 SW, 0x3 BEQ, 0x4 JMP, 0xF HALT; all others illegal.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, R_WB=4, MEM_ADDR=5, MEM_READ=6, MEM_WB=7, MEM_WRITE=8, BRANCH=9, JUMP=10, HALT=11, TRAP=12.
- Outputs are decoded from the state register only. Any strobe not listed for a state is 0.
- Reset (rst=0, async):
  - state=IDLE, retired_count=0.
  - All control outputs, halted and trap are 0.
  - Mid-instruction reset aborts the instruction immediately.
- IDLE: all 0; next cycle goes to FETCH.
- FETCH:
  - Always: C_MemRead=1, C_IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - C_IRWrite and C_PCWrite are asserted only when D_MemReady=1 (gated combinationally).
  - Stays in FETCH while D_MemReady=0; goes to DECODE when it is 1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state: 0x0→EXEC_R, 0x1/0x2→MEM_ADDR, 0x3→BRANCH, 0x4→JUMP, 0xF→HALT, illegal→see feature.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; goes to R_WB.
- R_WB: RegWrite=1, MemToReg=0; goes to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; goes to MEM_READ if OPCODE=0x1, else MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1; waits for D_MemReady, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1; goes to FETCH.
- MEM_WRITE:
  - MemWrite=1, IorD=1, held for the full stall.
  - Goes to FETCH on D_MemReady=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; goes to FETCH.
- JUMP: PCWrite=1, PCSource=10; goes to FETCH.
- HALT: all strobes 0, halted=1; terminal until reset.
- Retire counting:
  - retired_count increments by 1 on the edge leaving R_WB, MEM_WB, MEM_WRITE (with ready), BRANCH or JUMP toward FETCH.
  - It saturates at all-ones. HALT and TRAP do not count.
- Latency in cycles with ready asserted throughout: R-type=4, LW=5, SW=4, BEQ=3, JMP=3. Each ready-low cycle adds 1.
- OPCODE must be stable from DECODE to completion, because the IR only loads in FETCH.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to TRAP. TRAP asserts trap=1 with all strobes 0 and is terminal until reset.
- Undefined: an illegal opcode in DECODE goes straight to FETCH as a NOP, without counting as retired. trap is tied to 0 and the TRAP state is unreachable.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants.
  - state enumeration (4-bit).
  - ALUSrcB, ALUOp and PCSource encodings.
- Datapath blocks import the same encodings.
- One natural sub-module, sat_counter, for the parameterised saturating retire counter.
- The FSM (next-state plus output decode) stays in one module.

Test Plan:
- Reset pulse rst=0 mid-MEM_READ → state_o=0 and all outputs 0 immediately. After release: IDLE for 1 cycle, then FETCH.
- FETCH with D_MemReady low for 3 cycles, then high → C_MemRead=1 for 4 cycles, C_IRWrite/C_PCWrite=1 only on the 4th, then DECODE.
- OPCODE=0x1 with ready always high → states 1,2,5,6,7,1 in order. RegWrite=1 with MemToReg=1 in MEM_WB; retired_count 0→1.
- Sequence R-type, SW, BEQ, JMP (ready high) → retired_count=4. State visit counts: EXEC_R 1, MEM_WRITE 1, BRANCH 1, JUMP 1. PCWriteCond=1 only in BRANCH.
- OPCODE=0x7:
  - With ILLEGAL_TRAP_EN → state 12, trap=1, held for 100 cycles.
  - Without it → returns to FETCH, retired_count unchanged.
- CNT_W=4: run 20 R-type instructions → retired_count holds 15. OPCODE=0xF → halted=1, state_o=11 until reset.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control encodings for the 16-bit multi-cycle processor.
// The datapath imports the same opcodes, mux selects and state codes.
// The TRAP state is only reachable when ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_LW    = 4'h1;
   localparam logic [3:0] OP_SW    = 4'h2;
   localparam logic [3:0] OP_BEQ   = 4'h3;
   localparam logic [3:0] OP_JMP   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'hF;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXEC_R    = 4'd3,
      S_R_WB      = 4'd4,
      S_MEM_ADDR  = 4'd5,
      S_MEM_READ  = 4'd6,
      S_MEM_WB    = 4'd7,
      S_MEM_WRITE = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_HALT      = 4'd11,
      S_TRAP      = 4'd12
   } state_t;

   typedef enum logic [1:0] {
      SRCB_REG  = 2'b00,
      SRCB_ONE  = 2'b01,
      SRCB_SEXT = 2'b10,
      SRCB_BR   = 2'b11
   } alu_src_b_t;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_FUNC = 2'b10
   } alu_op_t;

   typedef enum logic [1:0] {
      PCS_ALU    = 2'b00,
      PCS_ALUOUT = 2'b01,
      PCS_JUMP   = 2'b10
   } pc_src_t;

   // Per-state strobes; IRWrite and the FETCH PC write are added by the
   // FSM because they also depend on memory ready.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      alu_src_b_t alu_src_b;
      alu_op_t    alu_op;
      pc_src_t    pc_source;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_ONE;
         end
         S_DECODE:   c.alu_src_b = SRCB_BR;
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_FUNC;
         end
         S_R_WB:     c.reg_write = 1'b1;
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_SEXT;
         end
         S_MEM_READ: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCS_ALUOUT;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCS_JUMP;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle: opcode and memory ready in, strobes out.
interface multicycle_control_fsm_if;

   logic [3:0] OPCODE;
   logic       D_MemReady;
   logic       C_IRWrite;
   logic       C_PCWrite;
   logic       C_PCWriteCond;
   logic       C_MemRead;
   logic       C_MemWrite;
   logic       C_IorD;
   logic       C_RegWrite;
   logic       C_MemToReg;
   logic       C_ALUSrcA;
   logic [1:0] C_ALUSrcB;
   logic [1:0] C_ALUOp;
   logic [1:0] C_PCSource;

   modport master (
      input  OPCODE, D_MemReady,
      output C_IRWrite, C_PCWrite, C_PCWriteCond, C_MemRead, C_MemWrite,
             C_IorD, C_RegWrite, C_MemToReg, C_ALUSrcA, C_ALUSrcB,
             C_ALUOp, C_PCSource
   );

   modport slave (
      output OPCODE, D_MemReady,
      input  C_IRWrite, C_PCWrite, C_PCWriteCond, C_MemRead, C_MemWrite,
             C_IorD, C_RegWrite, C_MemToReg, C_ALUSrcA, C_ALUSrcB,
             C_ALUOp, C_PCSource
   );

endinterface

// File: rtl/multicycle_control_fsm_sat_counter.sv
// Saturating up-counter used for the retired-instruction count.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc, stick at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the 16-bit multi-cycle processor.
// Strobes are registered from the next state, so they always reflect the
// state register; only IRWrite/PCWrite in FETCH are gated by memory ready.
// Optional: define ILLEGAL_TRAP_EN to trap illegal opcodes in a terminal
// TRAP state; otherwise illegal opcodes retire nothing and refetch.
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   multicycle_control_fsm_if.master bus,
   output logic [3:0]             state_o,
   output logic                   halted,
   output logic                   trap,
   output logic [CNT_W-1:0]       retired_count
);

   state_t state, nxt;
   ctrl_t  ctrl_q;
   logic   halted_q;
   logic   fetch_rdy;
   logic   retire;

   // Next-state selection.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:      nxt = S_FETCH;
         S_FETCH:     if (bus.D_MemReady) nxt = S_DECODE;
         S_DECODE: begin
            case (bus.OPCODE)
               OP_RTYPE:     nxt = S_EXEC_R;
               OP_LW, OP_SW: nxt = S_MEM_ADDR;
               OP_BEQ:       nxt = S_BRANCH;
               OP_JMP:       nxt = S_JUMP;
               OP_HALT:      nxt = S_HALT;
`ifdef ILLEGAL_TRAP_EN
               default:      nxt = S_TRAP;
`else
               default:      nxt = S_FETCH;
`endif
            endcase
         end
         S_EXEC_R:    nxt = S_R_WB;
         S_R_WB:      nxt = S_FETCH;
         S_MEM_ADDR:  nxt = (bus.OPCODE == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (bus.D_MemReady) nxt = S_MEM_WB;
         S_MEM_WB:    nxt = S_FETCH;
         S_MEM_WRITE: if (bus.D_MemReady) nxt = S_FETCH;
         S_BRANCH:    nxt = S_FETCH;
         S_JUMP:      nxt = S_FETCH;
         S_HALT:      nxt = S_HALT;
         S_TRAP:      nxt = S_TRAP;
         default:     nxt = S_IDLE;
      endcase
   end

   // An instruction retires on the edge that takes it back to FETCH.
   always_comb begin
      retire = 1'b0;
      case (state)
         S_R_WB, S_MEM_WB, S_BRANCH, S_JUMP: retire = 1'b1;
         S_MEM_WRITE:                        retire = bus.D_MemReady;
         default:                            retire = 1'b0;
      endcase
   end

`ifdef ILLEGAL_TRAP_EN
   logic trap_q;

   // State plus registered strobes/status, all derived from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         ctrl_q   <= '0;
         halted_q <= 1'b0;
         trap_q   <= 1'b0;
      end else begin
         state    <= nxt;
         ctrl_q   <= decode_ctrl(nxt);
         halted_q <= (nxt == S_HALT);
         trap_q   <= (nxt == S_TRAP);
      end
   end

   assign trap = trap_q;
`else
   // State plus registered strobes/status, all derived from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         ctrl_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         state    <= nxt;
         ctrl_q   <= decode_ctrl(nxt);
         halted_q <= (nxt == S_HALT);
      end
   end

   assign trap = 1'b0;
`endif

   sat_counter #(.W(CNT_W)) u_retire_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (retire),
      .count (retired_count)
   );

   // IR load and PC+1 write happen only when the fetch read completes.
   assign fetch_rdy         = (state == S_FETCH) && bus.D_MemReady;

   assign bus.C_IRWrite     = fetch_rdy;
   assign bus.C_PCWrite     = ctrl_q.pc_write | fetch_rdy;
   assign bus.C_PCWriteCond = ctrl_q.pc_write_cond;
   assign bus.C_MemRead     = ctrl_q.mem_read;
   assign bus.C_MemWrite    = ctrl_q.mem_write;
   assign bus.C_IorD        = ctrl_q.iord;
   assign bus.C_RegWrite    = ctrl_q.reg_write;
   assign bus.C_MemToReg    = ctrl_q.mem_to_reg;
   assign bus.C_ALUSrcA     = ctrl_q.alu_src_a;
   assign bus.C_ALUSrcB     = ctrl_q.alu_src_b;
   assign bus.C_ALUOp       = ctrl_q.alu_op;
   assign bus.C_PCSource    = ctrl_q.pc_source;

   assign state_o = state;
   assign halted  = halted_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-cycle vector table for
// the main instruction mix, then hand sequences for trap/NOP, async reset,
// HALT, and counter saturation on a CNT_W=4 instance.
// Honours ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_control_fsm;

   // Expected strobes packed as
   // {IRWrite,PCWrite,PCWriteCond,MemRead,MemWrite,IorD,RegWrite,MemToReg,
   //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
   localparam logic [14:0] C_NONE = 15'b000000000000000;
   localparam logic [14:0] C_FNR  = 15'b000100000010000;
   localparam logic [14:0] C_FR   = 15'b110100000010000;
   localparam logic [14:0] C_DEC  = 15'b000000000110000;
   localparam logic [14:0] C_EXR  = 15'b000000001001000;
   localparam logic [14:0] C_RWB  = 15'b000000100000000;
   localparam logic [14:0] C_MAD  = 15'b000000001100000;
   localparam logic [14:0] C_MRD  = 15'b000101000000000;
   localparam logic [14:0] C_MWB  = 15'b000000110000000;
   localparam logic [14:0] C_MWR  = 15'b000011000000000;
   localparam logic [14:0] C_BR   = 15'b001000001000101;
   localparam logic [14:0] C_JMP  = 15'b010000000000010;

   typedef struct {
      logic [3:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [14:0] ctl;
      logic [15:0] cnt;
      logic        h;
      logic        t;
   } vec_t;

   logic clk, rst, rst4;
   logic [3:0]  state_o, st4;
   logic        halted, trap, h4, t4;
   logic [15:0] retired_count;
   logic [3:0]  cnt4;
   logic [14:0] act_ctl;

   int n_vec = 0;
   int n_err = 0;
   vec_t tbl[$];

   multicycle_control_fsm_if bus ();
   multicycle_control_fsm_if bus4 ();

   multicycle_control_fsm #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus.master), .state_o(state_o),
      .halted(halted), .trap(trap), .retired_count(retired_count)
   );

   multicycle_control_fsm #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst4), .bus(bus4.master), .state_o(st4),
      .halted(h4), .trap(t4), .retired_count(cnt4)
   );

   assign act_ctl = {bus.C_IRWrite, bus.C_PCWrite, bus.C_PCWriteCond,
                     bus.C_MemRead, bus.C_MemWrite, bus.C_IorD,
                     bus.C_RegWrite, bus.C_MemToReg, bus.C_ALUSrcA,
                     bus.C_ALUSrcB, bus.C_ALUOp, bus.C_PCSource};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [3:0] op, input logic rdy, input logic [3:0] st,
                      input logic [14:0] ctl, input logic [15:0] cnt,
                      input logic h, input logic t);
      vec_t v;
      v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt; v.h = h; v.t = t;
      tbl.push_back(v);
   endtask

   initial begin
      int waited;
      rst = 1'b0; rst4 = 1'b0;
      bus.OPCODE = 4'h0;  bus.D_MemReady = 1'b0;
      bus4.OPCODE = 4'h0; bus4.D_MemReady = 1'b1;

      // Per-cycle vectors: current inputs and the outputs expected this cycle.
      add(4'h1, 1'b1, 4'd0,  C_NONE, 16'd0, 1'b0, 1'b0); // IDLE
      add(4'h1, 1'b0, 4'd1,  C_FNR,  16'd0, 1'b0, 1'b0); // FETCH stall x3
      add(4'h1, 1'b0, 4'd1,  C_FNR,  16'd0, 1'b0, 1'b0);
      add(4'h1, 1'b0, 4'd1,  C_FNR,  16'd0, 1'b0, 1'b0);
      add(4'h1, 1'b1, 4'd1,  C_FR,   16'd0, 1'b0, 1'b0); // LW
      add(4'h1, 1'b1, 4'd2,  C_DEC,  16'd0, 1'b0, 1'b0);
      add(4'h1, 1'b1, 4'd5,  C_MAD,  16'd0, 1'b0, 1'b0);
      add(4'h1, 1'b0, 4'd6,  C_MRD,  16'd0, 1'b0, 1'b0);
      add(4'h1, 1'b1, 4'd6,  C_MRD,  16'd0, 1'b0, 1'b0);
      add(4'h1, 1'b1, 4'd7,  C_MWB,  16'd0, 1'b0, 1'b0);
      add(4'h0, 1'b1, 4'd1,  C_FR,   16'd1, 1'b0, 1'b0); // R-type
      add(4'h0, 1'b1, 4'd2,  C_DEC,  16'd1, 1'b0, 1'b0);
      add(4'h0, 1'b1, 4'd3,  C_EXR,  16'd1, 1'b0, 1'b0);
      add(4'h0, 1'b1, 4'd4,  C_RWB,  16'd1, 1'b0, 1'b0);
      add(4'h2, 1'b1, 4'd1,  C_FR,   16'd2, 1'b0, 1'b0); // SW
      add(4'h2, 1'b1, 4'd2,  C_DEC,  16'd2, 1'b0, 1'b0);
      add(4'h2, 1'b1, 4'd5,  C_MAD,  16'd2, 1'b0, 1'b0);
      add(4'h2, 1'b0, 4'd8,  C_MWR,  16'd2, 1'b0, 1'b0);
      add(4'h2, 1'b1, 4'd8,  C_MWR,  16'd2, 1'b0, 1'b0);
      add(4'h3, 1'b1, 4'd1,  C_FR,   16'd3, 1'b0, 1'b0); // BEQ
      add(4'h3, 1'b1, 4'd2,  C_DEC,  16'd3, 1'b0, 1'b0);
      add(4'h3, 1'b1, 4'd9,  C_BR,   16'd3, 1'b0, 1'b0);
      add(4'h4, 1'b1, 4'd1,  C_FR,   16'd4, 1'b0, 1'b0); // JMP
      add(4'h4, 1'b1, 4'd2,  C_DEC,  16'd4, 1'b0, 1'b0);
      add(4'h4, 1'b1, 4'd10, C_JMP,  16'd4, 1'b0, 1'b0);
      add(4'h7, 1'b1, 4'd1,  C_FR,   16'd5, 1'b0, 1'b0); // illegal
      add(4'h7, 1'b1, 4'd2,  C_DEC,  16'd5, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
      add(4'h7, 1'b1, 4'd12, C_NONE, 16'd5, 1'b0, 1'b1);
`else
      add(4'h0, 1'b0, 4'd1,  C_FNR,  16'd5, 1'b0, 1'b0);
`endif

      // Reset state, asserted.
      #1;
      chk("reset state", state_o, 4'd0);
      chk("reset ctl", act_ctl, C_NONE);
      chk("reset cnt", retired_count, 16'd0);
      chk("reset halted/trap", {halted, trap}, 2'b00);

      @(posedge clk); #1;
      rst = 1'b1; rst4 = 1'b1;

      foreach (tbl[i]) begin
         bus.OPCODE = tbl[i].op;
         bus.D_MemReady = tbl[i].rdy;
         #1;
         chk($sformatf("v%0d state", i), state_o, tbl[i].st);
         chk($sformatf("v%0d ctl", i), act_ctl, tbl[i].ctl);
         chk($sformatf("v%0d cnt", i), retired_count, tbl[i].cnt);
         chk($sformatf("v%0d halted/trap", i), {halted, trap}, {tbl[i].h, tbl[i].t});
         step();
      end

`ifdef ILLEGAL_TRAP_EN
      // TRAP is terminal: hold for 100 cycles regardless of inputs.
      bus.OPCODE = 4'h0;
      for (int c = 0; c < 100; c++) begin
         if (state_o !== 4'd12 || trap !== 1'b1 || act_ctl !== C_NONE) begin
            chk($sformatf("trap hold c%0d", c), {state_o, trap, act_ctl}, {4'd12, 1'b1, C_NONE});
         end
         step();
      end
      chk("trap hold end", {state_o, trap, act_ctl}, {4'd12, 1'b1, C_NONE});
      chk("trap cnt", retired_count, 16'd5);
`else
      // Illegal opcode acted as a NOP; keep fetching normally.
      chk("nop state", state_o, 4'd1);
      chk("nop cnt", retired_count, 16'd5);
      chk("nop trap", trap, 1'b0);
`endif

      // Async reset: pulse, then run an LW into MEM_READ and abort it.
      rst = 1'b0; #1;
      chk("pulse state", state_o, 4'd0);
      rst = 1'b1;
      step();
      chk("rerun fetch", state_o, 4'd1);
      bus.OPCODE = 4'h1; bus.D_MemReady = 1'b1;
      step(); step(); step();
      bus.D_MemReady = 1'b0; #1;
      chk("pre-abort state", state_o, 4'd6);
      chk("pre-abort ctl", act_ctl, C_MRD);
      #1 rst = 1'b0; #1;
      chk("abort state", state_o, 4'd0);
      chk("abort ctl", act_ctl, C_NONE);
      chk("abort cnt/flags", {retired_count, halted, trap}, {16'd0, 2'b00});
      step();
      chk("held in reset", state_o, 4'd0);
      rst = 1'b1; bus.D_MemReady = 1'b1; #1;
      chk("idle after release", state_o, 4'd0);
      step();
      chk("fetch after idle", state_o, 4'd1);

      // HALT is terminal until reset.
      bus.OPCODE = 4'hF;
      step(); step();
      chk("halt state", state_o, 4'd11);
      chk("halt flags", {halted, trap}, 2'b10);
      chk("halt ctl", act_ctl, C_NONE);
      bus.OPCODE = 4'h0;
      repeat (5) step();
      chk("halt held", {state_o, halted}, {4'd11, 1'b1});
      chk("halt cnt", retired_count, 16'd0);

      // CNT_W=4 instance has been running R-types; ensure >20 retired.
      repeat (90) step();
      chk("sat cnt", cnt4, 4'd15);
      bus4.OPCODE = 4'hF;
      waited = 0;
      while (st4 !== 4'd11 && waited < 10) begin
         step();
         waited++;
      end
      chk("sat halt state", st4, 4'd11);
      chk("sat halted", h4, 1'b1);
      repeat (3) step();
      chk("sat halt hold", {st4, cnt4}, {4'd11, 4'd15});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
